counter_1k: RTL and testbench

COUNTER_1K -- requirements
Module: counter_1k

---
 rtl/counter_1k.sv | 111 +++++++++++
 tb/tb_counter_1k.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/counter_1k.sv
// counter_1k: 0..MAX_COUNT up/down counter stepped at TICK_HZ, with a
// synchronised, edge-detected asynchronous LOAD and saturating load clamp.
module counter_1k #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned MAX_COUNT = 999
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       EN,
  input  logic       UP_DN,
  input  logic       LOAD,
  input  logic [9:0] LOAD_VAL,
  output logic [9:0] BIN,
  output logic       TICK,
  output logic       WRAP
);

  localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [9:0]    MAXC     = 10'(MAX_COUNT);

  logic [PW-1:0] pre_q, pre_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          valid_q, arm_q;
  logic [9:0]    bin_q, bin_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic          load_pulse;
  logic          pre_last;
  logic [9:0]    load_value;

  // arm_q only sets once the synchronizer has captured a genuine low sample
  // after reset, so a LOAD already high at reset release never loads.
  assign load_pulse = arm_q & sync2_q & ~prev_q;
  assign pre_last   = (pre_q == PRE_LAST);
  assign load_value = (LOAD_VAL > MAXC) ? MAXC : LOAD_VAL;

  // LOAD synchronizer, edge-detect history and re-arm tracking
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      valid_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      sync1_q <= LOAD;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b1;
      arm_q   <= arm_q | (valid_q & ~sync1_q);
    end
  end

  // Prescaler next state: free-running 0..DIV-1, cleared by a load
  always_comb begin
    pre_d = pre_q + 1'b1;
    if (load_pulse || pre_last) begin
      pre_d = '0;
    end
  end

  // Count, step strobe and wrap strobe next state; load beats a step
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    tick_d = pre_last;
    if (load_pulse) begin
      bin_d = load_value;
    end else if (pre_last && EN) begin
      if (UP_DN) begin
        if (bin_q >= MAXC) begin
          bin_d  = '0;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q + 10'd1;
        end
      end else begin
        if (bin_q == '0) begin
          bin_d  = MAXC;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q - 10'd1;
        end
      end
    end
  end

  // Prescaler, count and strobe registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q  <= '0;
      bin_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      bin_q  <= bin_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign BIN  = bin_q;
  assign TICK = tick_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_counter_1k.sv
// Directed bench for counter_1k with DIV = 10, MAX_COUNT = 999.
module tb_counter_1k;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       EN;
  logic       UP_DN;
  logic       LOAD;
  logic [9:0] LOAD_VAL;
  logic [9:0] BIN;
  logic       TICK;
  logic       WRAP;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  counter_1k #(
    .CLK_HZ   (10),
    .TICK_HZ  (1),
    .MAX_COUNT(999)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .EN      (EN),
    .UP_DN   (UP_DN),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .BIN     (BIN),
    .TICK    (TICK),
    .WRAP    (WRAP)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         ncyc;
    logic       en;
    logic       up;
    logic       load;
    logic [9:0] lval;
    logic [9:0] bin;
    logic       tick;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [9:0] b,
                         input logic t, input logic w);
    chk({name, ".BIN"}, int'(BIN), int'(b));
    chk({name, ".TICK"}, int'(TICK), int'(t));
    chk({name, ".WRAP"}, int'(WRAP), int'(w));
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  function automatic vec_t mk(input int n, input logic en, input logic up,
                              input logic ld, input int lv, input int b,
                              input logic t, input logic w);
    vec_t v;
    v.ncyc = n; v.en = en; v.up = up; v.load = ld; v.lval = 10'(lv);
    v.bin = 10'(b); v.tick = t; v.wrap = w;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Edge numbers after reset release noted per row (edge1 at t=15).
    vecs.push_back(mk( 9, 1, 1, 0,    0,   0, 0, 0)); // e9
    vecs.push_back(mk( 1, 1, 1, 0,    0,   1, 1, 0)); // e10 first step
    vecs.push_back(mk( 1, 1, 1, 0,    0,   1, 0, 0)); // e11
    vecs.push_back(mk( 9, 1, 1, 0,    0,   2, 1, 0)); // e20
    vecs.push_back(mk(10, 1, 1, 0,    0,   3, 1, 0)); // e30
    vecs.push_back(mk( 5, 1, 1, 0,    0,   3, 0, 0)); // e35
    vecs.push_back(mk( 2, 1, 1, 1,  998,   3, 0, 0)); // e37 load pending
    vecs.push_back(mk( 1, 1, 1, 0,  998, 998, 0, 0)); // e38 load, pre=0
    vecs.push_back(mk(10, 1, 1, 0,  998, 999, 1, 0)); // e48
    vecs.push_back(mk( 9, 1, 1, 0,  998, 999, 0, 0)); // e57
    vecs.push_back(mk( 1, 1, 1, 0,  998,   0, 1, 1)); // e58 up wrap
    vecs.push_back(mk( 1, 1, 1, 0,  998,   0, 0, 0)); // e59
    vecs.push_back(mk( 2, 1, 0, 1,    1,   0, 0, 0)); // e61
    vecs.push_back(mk( 1, 1, 0, 0,    1,   1, 0, 0)); // e62 load 1
    vecs.push_back(mk(10, 1, 0, 0,    1,   0, 1, 0)); // e72
    vecs.push_back(mk(10, 1, 0, 0,    1, 999, 1, 1)); // e82 down wrap
    vecs.push_back(mk( 1, 1, 0, 0,    1, 999, 0, 0)); // e83
    vecs.push_back(mk( 9, 1, 0, 0,    1, 998, 1, 0)); // e92
    vecs.push_back(mk( 2, 1, 1, 1, 1023, 998, 0, 0)); // e94 still pending
    vecs.push_back(mk( 1, 1, 1, 1, 1023, 999, 0, 0)); // e95 clamped load
    vecs.push_back(mk( 9, 1, 1, 1, 1023, 999, 0, 0)); // e104
    vecs.push_back(mk( 1, 1, 1, 1, 1023,   0, 1, 1)); // e105
    vecs.push_back(mk(38, 1, 1, 1, 1023,   3, 0, 0)); // e143 held, no reload
    vecs.push_back(mk( 2, 1, 1, 0,    5,   4, 1, 0)); // e145
    vecs.push_back(mk( 7, 1, 1, 0,    5,   4, 0, 0)); // e152
    vecs.push_back(mk( 2, 1, 1, 1,    5,   4, 0, 0)); // e154
    vecs.push_back(mk( 1, 1, 1, 1,    5,   5, 1, 0)); // e155 load meets step
    vecs.push_back(mk( 9, 1, 1, 0,    5,   5, 0, 0)); // e164
    vecs.push_back(mk( 1, 1, 1, 0,    5,   6, 1, 0)); // e165 prescaler restarted
    vecs.push_back(mk(30, 0, 1, 0,    5,   6, 1, 0)); // e195 EN=0 holds

    RESET_N = 1'b0; EN = 1'b1; UP_DN = 1'b1; LOAD = 1'b0; LOAD_VAL = '0;
    #12;
    chk_all("reset", 10'd0, 1'b0, 1'b0);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      EN = vecs[i].en; UP_DN = vecs[i].up;
      LOAD = vecs[i].load; LOAD_VAL = vecs[i].lval;
      run(vecs[i].ncyc);
      chk_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].tick, vecs[i].wrap);
    end

    // Asynchronous reset mid-cycle with no clock edge
    #3;
    RESET_N = 1'b0;
    #1;
    chk_all("async_rst", 10'd0, 1'b0, 1'b0);

    // LOAD already high at reset release must not load
    EN = 1'b0; UP_DN = 1'b1; LOAD = 1'b1; LOAD_VAL = 10'd7;
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    run(20);
    chk("held_at_release", int'(BIN), 0);
    LOAD = 1'b0;
    run(3);
    chk("after_fall", int'(BIN), 0);
    LOAD = 1'b1;
    run(2);
    chk("latency_edge2", int'(BIN), 0);
    run(1);
    chk("latency_edge3", int'(BIN), 7);

    // Reset in the middle of a load discards it
    LOAD = 1'b0;
    run(3);
    LOAD_VAL = 10'd9;
    LOAD = 1'b1;
    run(1);
    RESET_N = 1'b0;
    #2;
    LOAD = 1'b0;
    chk("midload_rst", int'(BIN), 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    run(5);
    chk("midload_discard", int'(BIN), 0);
    LOAD = 1'b1;
    run(3);
    chk("reload_after_rst", int'(BIN), 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
